// File: rtl/ipg_pkg.sv
// ipg_pkg: sync headers, block types and idle-lane capacity shared by IPG TX/RX
package ipg_pkg;
  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;
  localparam logic [7:0] BLOCK_TYPE_C    = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_CO   = 8'h2d;
  localparam logic [7:0] BLOCK_TYPE_CS   = 8'h33;
  localparam logic [7:0] BLOCK_TYPE_OC   = 8'h4b;
  localparam logic [7:0] BLOCK_TYPE_T0   = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_T1   = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_T2   = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_T3   = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_T4   = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_T5   = 8'hd2;
  typedef struct packed {
    logic [2:0] first;
    logic [3:0] n;
  } cap_t;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  function automatic cap_t capacity(input logic [7:0] bt);
    case (bt)
      BLOCK_TYPE_C:                capacity = '{3'd1, 4'd7};
      BLOCK_TYPE_CO, BLOCK_TYPE_CS: capacity = '{3'd1, 4'd3};
      BLOCK_TYPE_OC:               capacity = '{3'd5, 4'd3};
      BLOCK_TYPE_T0:               capacity = '{3'd2, 4'd6};
      BLOCK_TYPE_T1:               capacity = '{3'd3, 4'd5};
      BLOCK_TYPE_T2:               capacity = '{3'd4, 4'd4};
      BLOCK_TYPE_T3:               capacity = '{3'd5, 4'd3};
      BLOCK_TYPE_T4:               capacity = '{3'd6, 4'd2};
      BLOCK_TYPE_T5:               capacity = '{3'd7, 4'd1};
      default:                     capacity = '{3'd0, 4'd0};
    endcase
  endfunction
endpackage

// File: rtl/ipg_rr_arbiter.sv
// ipg_rr_arbiter: message-atomic round-robin arbiter, grant held until last handshake
module ipg_rr_arbiter
  import ipg_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 last_hs,
  output logic                 grant_vld,
  output logic [REQ_IDX_W-1:0] grant_idx
);
  arb_state_t state, state_next;
  logic [REQ_IDX_W-1:0] ptr, ptr_next, idx_next, pick;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_next;
      grant_idx <= idx_next;
      ptr       <= ptr_next;
    end
  // scan downward so the lowest offset from ptr wins
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) pick = REQ_IDX_W'((int'(ptr) + k) % NUM_REQ);
  end
  always_comb begin
    state_next = state;
    idx_next   = grant_idx;
    ptr_next   = ptr;
    if (state == ARB_IDLE && |req) begin
      state_next = ARB_BUSY;
      idx_next   = pick;
    end
    if (state == ARB_BUSY && last_hs) begin
      state_next = ARB_IDLE;
      ptr_next   = (grant_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
  always_comb grant_vld = state == ARB_BUSY;
endmodule

// File: rtl/ipg_tx_sched.sv
// ipg_tx_sched: stages requester words and inserts them into idle lanes of control blocks
module ipg_tx_sched
  import ipg_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ipg_en,
  input  logic [1:0]             encoded_tx_hdr,
  input  logic [63:0]            encoded_tx_data,
  input  logic [NUM_REQ-1:0]     s_valid,
  input  logic [64*NUM_REQ-1:0]  s_data,
  input  logic [NUM_REQ-1:0]     s_last,
  output logic [NUM_REQ-1:0]     s_ready,
  output logic [1:0]             out_tx_hdr,
  output logic [63:0]            out_tx_data,
  output logic [5:0]             tx_len,
  output logic                   grant_vld,
  output logic [REQ_IDX_W-1:0]   grant_idx
);
  logic [127:0] stage, stage_next;
  logic [4:0]   count, count_next, rem;
  logic [63:0]  word, ins_data;
  logic         load, last_hs;
  cap_t         cap;
  logic [7:0]   lane_busy;
  logic [3:0]   avail, taken;
  ipg_rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_IDX_W(REQ_IDX_W)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (s_valid),
    .last_hs   (last_hs),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );
  assign s_ready = (grant_vld && count <= 5'd8) ? NUM_REQ'(1) << grant_idx : '0;
  assign load    = |(s_valid & s_ready);
  assign last_hs = load && s_last[grant_idx];
  assign word    = s_data[64*grant_idx +: 64];
  always_comb begin
    cap       = encoded_tx_hdr == SYNC_CTRL ? capacity(encoded_tx_data[7:0]) : '0;
    lane_busy = '0;
    for (int l = 1; l < 8; l++)
      lane_busy[l] = l >= int'(cap.first) && l < int'(cap.first) + int'(cap.n) && |encoded_tx_data[8*l +: 8];
    avail    = |lane_busy ? 4'd0 : cap.n;
    taken    = !ipg_en ? 4'd0 : (5'(avail) <= count ? avail : count[3:0]);
    ins_data = encoded_tx_data;
    // eligible lanes are already zero, so only the filled ones need writing
    for (int l = 1; l < 8; l++)
      if (l >= int'(cap.first) && l - int'(cap.first) < int'(taken))
        ins_data[8*l +: 8] = stage[8*(l - int'(cap.first)) +: 8];
    rem        = count - 5'(taken);
    count_next = rem + (load ? 5'd8 : 5'd0);
    stage_next = (stage >> {taken, 3'b000}) | (load ? 128'(word) << {rem, 3'b000} : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_tx_hdr  <= '0;
      out_tx_data <= '0;
      tx_len      <= '0;
      count       <= '0;
      stage       <= '0;
    end else begin
      out_tx_hdr  <= encoded_tx_hdr;
      out_tx_data <= ins_data;
      tx_len      <= {taken[2:0], 3'b000};
      count       <= count_next;
      stage       <= stage_next;
    end
endmodule
